uart_tx_fifo: RTL and testbench

Buffered UART transmitter feeding the board-level `uart_txd` pin of `system`. It accepts bytes from the on-chip producer through a write-strobe interface and stores them in a small FIFO. It serializes each byte as 8N1 at `uart_baud_rate`, derived from `clk_freq`. It is the last stage before the pad, so its timing sets what the system testbench decodes on `uart_txd`.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_fifo_if.sv | 13 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 78 +++++++
 tb/tb_uart_tx_fifo.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, frame constants and baud divisor rounding
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write strobe, FIFO status flags and the serial line
interface uart_tx_fifo_if;
    import uart_pkg::*;
    logic [UART_DATA_BITS-1:0] tx_data;
    logic tx_wr;
    logic tx_full;
    logic tx_empty;
    logic tx_busy;
    logic tx_overflow;
    logic uart_txd;
    modport master (output tx_data, tx_wr, input tx_full, tx_empty, tx_busy, tx_overflow, uart_txd);
    modport slave (input tx_data, tx_wr, output tx_full, tx_empty, tx_busy, tx_overflow, uart_txd);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with combinational head and registered full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH %0d must be a power of two >= 2", DEPTH);
    end
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q, cnt_d;
    logic full_q, empty_q, push, pop;
    assign push = wr && !full_q;
    assign pop = rd && !empty_q;
    assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp_q <= wp_q + AW'(push);
            rp_q <= rp_q + AW'(pop);
            cnt_q <= cnt_d;
            full_q <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wdata;
    end
    assign rdata = mem_q[rp_q];
    assign full = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter driving the pad from a flop
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq = 100000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth = 16
) (
    input logic clk,
    input logic rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = uart_div(clk_freq, uart_baud_rate);
    localparam int CW = $clog2(DIV);
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: baud divisor %0d is below 2", DIV);
    end
    uart_tx_state_t state_q;
    logic [CW-1:0] baud_q;
    logic [2:0] bit_q;
    logic [UART_DATA_BITS-1:0] shift_q, head;
    logic txd_q, ovf_q, pop, empty, full, tick;
    assign tick = baud_q == CW'(DIV - 1);
    // pops only on registered non-empty, so a just-written byte waits one cycle
    assign pop = !empty && (state_q == IDLE || (state_q == STOP && tick));
    sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(fifo_depth)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr(bus.tx_wr),
        .wdata(bus.tx_data),
        .rd(pop),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            txd_q <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            if (bus.tx_wr && full) ovf_q <= 1'b1;
            baud_q <= (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    shift_q <= head;
                    txd_q <= 1'b0;
                end
                START: if (tick) begin
                    state_q <= DATA;
                    bit_q <= '0;
                    txd_q <= shift_q[0];
                end
                DATA: if (tick) begin
                    shift_q <= shift_q >> 1;
                    bit_q <= bit_q + 1'b1;
                    state_q <= bit_q == 3'd7 ? STOP : DATA;
                    txd_q <= bit_q == 3'd7 ? 1'b1 : shift_q[1];
                end
                STOP: if (tick) begin
                    state_q <= pop ? START : IDLE;
                    shift_q <= head;
                    txd_q <= !pop;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.uart_txd = txd_q;
    assign bus.tx_full = full;
    assign bus.tx_empty = empty;
    assign bus.tx_busy = !empty || state_q != IDLE;
    assign bus.tx_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed writes feed an expected-byte queue; a line decoder pops and checks each frame
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DIV = 87;
    localparam int FRAME = 10 * DIV;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_tx_fifo_if bus();
    uart_tx_fifo dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cyc = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    bit m_act = 1'b0;
    bit m_has;
    int m_cnt, m_err, n_bit;
    logic [7:0] m_exp, m_rx;
    logic [9:0] frame;
    always @(negedge clk) begin
        if (rst) m_act = 1'b0;
        else if (!m_act) begin
            if (!bus.uart_txd) begin
                m_act = 1'b1;
                m_cnt = 0;
                m_err = 0;
                m_rx = 8'h00;
                starts.push_back(cyc);
                m_has = exp_q.size() > 0;
                m_exp = m_has ? exp_q.pop_front() : 8'h00;
            end
        end else m_cnt++;
        if (m_act && !rst) begin
            n_bit = m_cnt / DIV;
            frame = {1'b1, m_exp, 1'b0};
            if (bus.uart_txd !== frame[n_bit]) m_err++;
            if (m_cnt % DIV == DIV / 2 && n_bit >= 1 && n_bit <= 8) m_rx[n_bit-1] = bus.uart_txd;
            if (m_cnt == FRAME - 1) begin
                check("frame_expected", 32'(m_has), 1);
                check("rx_byte", 32'(m_rx), 32'(m_exp));
                check("bit_timing_errs", m_err, 0);
                m_act = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] b, input bit acc);
        bus.tx_data = b;
        bus.tx_wr = 1'b1;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        bus.tx_wr = 1'b0;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int limit, output int fall);
        int n = 0;
        @(negedge clk);
        while (bus.tx_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        fall = cyc;
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy after %0d cycles, want idle", limit);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fall, errs, n;
        bus.tx_data = 8'h00;
        bus.tx_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_txd", bus.uart_txd, 1);
        check("rst_full", bus.tx_full, 0);
        check("rst_empty", bus.tx_empty, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_ovf", bus.tx_overflow, 0);
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.uart_txd !== 1'b1 || bus.tx_empty !== 1'b1 || bus.tx_busy !== 1'b0) errs++;
        end
        check("idle_quiet", errs, 0);

        starts.delete();
        wr(8'h55, 1'b1);
        k = wr_cyc;
        check("wr_empty_falls", bus.tx_empty, 0);
        check("wr_busy_rises", bus.tx_busy, 1);
        wait_idle(2000, fall);
        check("frames_55", starts.size(), 1);
        if (starts.size() >= 1) check("start_latency", starts[0] - k, 1);
        check("busy_fall_55", fall - k, FRAME + 1);
        check("drained_55", exp_q.size(), 0);

        starts.delete();
        wr(8'h41, 1'b1);
        k = wr_cyc;
        wr(8'h50, 1'b1);
        wr(8'h4F, 1'b1);
        wait_idle(4000, fall);
        check("frames_apo", starts.size(), 3);
        if (starts.size() == 3) begin
            check("gap_apo_1", starts[1] - starts[0], FRAME);
            check("gap_apo_2", starts[2] - starts[1], FRAME);
        end
        check("busy_fall_apo", fall - k, 3 * FRAME + 1);
        check("drained_apo", exp_q.size(), 0);

        starts.delete();
        for (int i = 0; i < 17; i++) wr(8'(i * 13 + 7), 1'b1);
        check("full_at_16", bus.tx_full, 1);
        check("ovf_before_drop", bus.tx_overflow, 0);
        wr(8'hEE, 1'b0);
        check("ovf_after_drop", bus.tx_overflow, 1);
        check("full_after_drop", bus.tx_full, 1);
        wait_idle(17 * FRAME + 200, fall);
        check("frames_ovf", starts.size(), 17);
        check("drained_ovf", exp_q.size(), 0);
        check("ovf_sticky", bus.tx_overflow, 1);
        check("empty_after_ovf", bus.tx_empty, 1);

        starts.delete();
        for (int i = 0; i < 4; i++) wr(8'(8'hC3 + i), 1'b1);
        n = 0;
        while (!(m_act && m_cnt == 4 * DIV + DIV / 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit3", 32'(n < 2000), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_txd", bus.uart_txd, 1);
        check("rst_mid_empty", bus.tx_empty, 1);
        check("rst_mid_busy", bus.tx_busy, 0);
        check("rst_mid_ovf", bus.tx_overflow, 0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        errs = 0;
        repeat (2000) begin
            @(negedge clk);
            if (bus.uart_txd !== 1'b1 || bus.tx_empty !== 1'b1) errs++;
        end
        check("post_rst_quiet", errs, 0);
        check("post_rst_frames", starts.size(), 1);

        starts.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) wr(8'(r * 16 + i + 8'h20), 1'b1);
            if (r == 0) check("not_full_15", bus.tx_full, 0);
            wait_idle(16 * FRAME + 200, fall);
        end
        check("frames_wrap", starts.size(), 48);
        check("drained_wrap", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
